// File: rtl/muldiv_unit_if.sv
// Handshake/bus bundle between the decoder/pipeline and the M-extension
// multiply/divide unit.
interface muldiv_unit_if;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  // Pipeline side: issues operations, consumes status/result.
  modport master (
    output start_i, funct3_i, op_a_i, op_b_i, flush_i,
    input  busy_o, done_o, result_o
  );

  // Unit side.
  modport slave (
    input  start_i, funct3_i, op_a_i, op_b_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle over 32 CALC cycles. Divide-by-zero
// and signed-overflow divides skip straight to DONE.
module muldiv_unit (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave mdu
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [63:0] mcand_q;   // multiplicand (shifted left) or divisor magnitude
  logic [31:0] mplier_q;  // multiplier, consumed LSB first
  logic [63:0] acc_q;     // product, or {remainder, dividend/quotient}
  logic        qneg_q;
  logic        rneg_q;
  logic [31:0] result_q;

  // Acceptance-time decode of the incoming operation
  logic        in_div;
  logic        in_sdiv;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        div_ovf;
  logic        special;
  logic [31:0] special_res;
  logic [63:0] mul_a_ext;

  always_comb begin
    in_div    = mdu.funct3_i[2];
    in_sdiv   = mdu.funct3_i[2] & ~mdu.funct3_i[0];
    a_neg     = in_sdiv & mdu.op_a_i[31];
    b_neg     = in_sdiv & mdu.op_b_i[31];
    a_mag     = a_neg ? -mdu.op_a_i : mdu.op_a_i;
    b_mag     = b_neg ? -mdu.op_b_i : mdu.op_b_i;
    div_zero  = in_div && (mdu.op_b_i == '0);
    div_ovf   = in_sdiv && (mdu.op_a_i == 32'h8000_0000) && (mdu.op_b_i == '1);
    special   = div_zero | div_ovf;
    if (div_zero) begin
      special_res = mdu.funct3_i[1] ? mdu.op_a_i : '1;
    end else begin
      special_res = mdu.funct3_i[1] ? '0 : 32'h8000_0000;
    end
    if ((mdu.funct3_i == 3'b001) || (mdu.funct3_i == 3'b010)) begin
      mul_a_ext = {{32{mdu.op_a_i[31]}}, mdu.op_a_i};
    end else begin
      mul_a_ext = {32'b0, mdu.op_a_i};
    end
  end

  // One iteration of the datapath and the final result formatting
  logic        is_div;
  logic        mul_b_signed;
  logic [63:0] addend;
  logic [63:0] mul_step;
  logic [64:0] div_sh;
  logic [33:0] div_trial;
  logic [63:0] div_step;
  logic [63:0] acc_d;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fin_res;

  always_comb begin
    is_div       = f3_q[2];
    mul_b_signed = (f3_q == 3'b001);
    addend       = mplier_q[0] ? mcand_q : '0;
    // A signed multiplier's bit 31 carries weight -2^31, so its partial
    // product is subtracted on the last iteration.
    if (mul_b_signed && (cnt_q == 6'd31)) begin
      mul_step = acc_q - addend;
    end else begin
      mul_step = acc_q + addend;
    end
    div_sh    = {acc_q, 1'b0};
    div_trial = {1'b0, div_sh[64:32]} - {2'b0, mcand_q[31:0]};
    if (!div_trial[33]) begin
      div_step = {div_trial[31:0], div_sh[31:1], 1'b1};
    end else begin
      div_step = div_sh[63:0];
    end
    acc_d = is_div ? div_step : mul_step;
    quo   = acc_d[31:0];
    rem   = acc_d[63:32];
    case (f3_q)
      3'b000:                 fin_res = acc_d[31:0];
      3'b001, 3'b010, 3'b011: fin_res = acc_d[63:32];
      3'b100, 3'b101:         fin_res = qneg_q ? -quo : quo;
      default:                fin_res = rneg_q ? -rem : rem;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else if (mdu.flush_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mdu.start_i) begin
            f3_q  <= mdu.funct3_i;
            cnt_q <= '0;
            if (in_div) begin
              acc_q    <= {32'b0, a_mag};
              mcand_q  <= {32'b0, b_mag};
              mplier_q <= '0;
              qneg_q   <= a_neg ^ b_neg;
              rneg_q   <= a_neg;
            end else begin
              acc_q    <= '0;
              mcand_q  <= mul_a_ext;
              mplier_q <= mdu.op_b_i;
              qneg_q   <= 1'b0;
              rneg_q   <= 1'b0;
            end
            if (special) begin
              result_q <= special_res;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          if (!is_div) begin
            mcand_q <= mcand_q << 1;
          end
          if (cnt_q == 6'd31) begin
            result_q <= fin_res;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from state
  always_comb begin
    mdu.busy_o   = (state_q != S_IDLE);
    mdu.done_o   = (state_q == S_DONE);
    mdu.result_o = result_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table with a result
// scoreboard, plus hand-written held-start, flush and mid-op reset cases.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard: every done_o pulse pops one expected result
  always @(negedge clk) begin
    if (rst_n && bus.done_o) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got result 0x%08h expected no done_o", bus.result_o);
      end else begin
        check(name_q.pop_front(), bus.result_o, exp_q.pop_front());
      end
    end
  end

  // From just after the acceptance edge, count edges until done_o is seen
  task automatic wait_done(input string name, input int exp_lat);
    int edges;
    edges = 1;
    forever begin
      @(negedge clk);
      if (bus.done_o) break;
      if (edges >= 60) break;
      @(posedge clk);
      edges++;
    end
    check({name, " latency"}, 32'(edges), 32'(exp_lat));
  endtask

  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat);
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.funct3_i = f3;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    exp_q.push_back(res);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.op_a_i  = $urandom;
    bus.op_b_i  = $urandom;
    wait_done(name, lat);
  endtask

  task automatic count_no_done(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done_o) hits++;
    end
    check(name, 32'(hits), 32'd0);
  endtask

  logic [31:0] last_res;

  initial begin
    vecs[0]  = '{"MUL 7x-3",        3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{"MULH 7x-3",       3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
    vecs[2]  = '{"MULHU 7x-3",      3'b011, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 33};
    vecs[3]  = '{"MULHSU 7x-3",     3'b010, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 33};
    vecs[4]  = '{"MULHSU -1x2",     3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[5]  = '{"MULHU max",       3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[6]  = '{"MULH minxmin",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[7]  = '{"MUL shift",       3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33};
    vecs[8]  = '{"DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[9]  = '{"REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[10] = '{"DIVU max/2",      3'b101, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF, 33};
    vecs[11] = '{"DIV 7/-2",        3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[12] = '{"REM 7/-2",        3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[13] = '{"DIVU 100/7",      3'b101, 32'd100,       32'd7,         32'd14,        33};
    vecs[14] = '{"REMU 100/7",      3'b111, 32'd100,       32'd7,         32'd2,         33};
    vecs[15] = '{"DIV min/1",       3'b100, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 33};
    vecs[16] = '{"DIVU 7/max",      3'b101, 32'd7,         32'hFFFF_FFFF, 32'd0,         33};
    vecs[17] = '{"DIV 5/0",         3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[18] = '{"REMU 5/0",        3'b111, 32'd5,         32'd0,         32'd5,         1};
    vecs[19] = '{"DIVU 9/0",        3'b101, 32'd9,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[20] = '{"DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[21] = '{"REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};

    rst_n        = 1'b0;
    bus.start_i  = 1'b0;
    bus.flush_i  = 1'b0;
    bus.funct3_i = '0;
    bus.op_a_i   = '0;
    bus.op_b_i   = '0;

    // Reset state
    #2;
    check("reset busy",   32'(bus.busy_o), 32'd0);
    check("reset done",   32'(bus.done_o), 32'd0);
    check("reset result", bus.result_o,    32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end
    last_res = vecs[NV-1].res;

    // start_i held high with changing operands: only first-latched ones count
    begin
      int edges;
      @(negedge clk);
      bus.start_i  = 1'b1;
      bus.funct3_i = 3'b000;
      bus.op_a_i   = 32'd3;
      bus.op_b_i   = 32'd5;
      exp_q.push_back(32'd15);
      name_q.push_back("held MUL 3x5");
      @(posedge clk);
      edges = 1;
      forever begin
        @(negedge clk);
        if (bus.done_o || edges >= 60) break;
        bus.funct3_i = 3'(($urandom_range(0, 3)));
        bus.op_a_i   = $urandom;
        bus.op_b_i   = $urandom;
        @(posedge clk);
        edges++;
      end
      check("held latency", 32'(edges), 32'd33);
      bus.funct3_i = 3'b000;
      bus.op_a_i   = 32'd2;
      bus.op_b_i   = 32'd2;
      exp_q.push_back(32'd4);
      name_q.push_back("held MUL 2x2");
      @(negedge clk);
      check("held idle after done", 32'(bus.busy_o), 32'd0);
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      wait_done("held second op", 33);
      last_res = 32'd4;
    end

    // Flush at CALC iteration 10
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.funct3_i = 3'b000;
    bus.op_a_i   = 32'd11;
    bus.op_b_i   = 32'd13;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush busy",   32'(bus.busy_o), 32'd0);
    check("flush result", bus.result_o,    last_res);
    count_no_done("flush no done", 40);

    // start and flush together in IDLE: start dropped
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("start+flush busy", 32'(bus.busy_o), 32'd0);
    count_no_done("start+flush no done", 40);

    // Reset pulse mid-CALC
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.funct3_i = 3'b101;
    bus.op_a_i   = 32'd1000;
    bus.op_b_i   = 32'd3;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("mid-op busy before reset", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset busy",   32'(bus.busy_o), 32'd0);
    check("async reset done",   32'(bus.done_o), 32'd0);
    check("async reset result", bus.result_o,    32'd0);
    #1;
    rst_n = 1'b1;
    count_no_done("post reset no done", 40);

    // Recovery after reset
    do_op("post reset DIVU", 3'b101, 32'd1000, 32'd3, 32'd333, 33);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
